// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcode/funct constants and decode predicates shared by hazard and forwarding logic.
package mips_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] F_JR       = 6'h08;
    localparam logic [5:0] F_JALR     = 6'h09;
    localparam logic [5:0] F_MFHI     = 6'h10;
    localparam logic [5:0] F_MTHI     = 6'h11;
    localparam logic [5:0] F_MFLO     = 6'h12;
    localparam logic [5:0] F_MTLO     = 6'h13;
    localparam logic [5:0] F_MULT     = 6'h18;
    localparam logic [5:0] F_DIVU     = 6'h1B;

    typedef enum logic {IDLE, BUSY} md_state_t;

    function automatic logic is_load(input logic [31:0] ir);
        return ir[31:26] inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_md(input logic [31:0] ir);
        return ir[31:26] == OP_SPECIAL && ir[5:0] >= F_MULT && ir[5:0] <= F_DIVU;
    endfunction

    function automatic logic is_hilo(input logic [31:0] ir);
        return ir[31:26] == OP_SPECIAL && ir[5:0] >= F_MFHI && ir[5:0] <= F_MTLO;
    endfunction

    function automatic logic is_branch_d(input logic [31:0] ir);
        return ir[31:26] == OP_BEQ || ir[31:26] == OP_BNE ||
               (ir[31:26] == OP_SPECIAL && (ir[5:0] == F_JR || ir[5:0] == F_JALR));
    endfunction

    function automatic logic [4:0] dest_reg(input logic [31:0] ir);
        if (ir[31:26] == OP_SPECIAL)
            return (ir[5:0] == F_JR || is_md(ir) || ir[5:0] == F_MTHI || ir[5:0] == F_MTLO) ? 5'd0 : ir[15:11];
        if (is_load(ir) || ir[31:29] == 3'b001)
            return ir[20:16];
        return ir[31:26] == OP_JAL ? 5'd31 : 5'd0;
    endfunction

    // $0 is hardwired, so a write to it never creates a dependency
    function automatic logic hits(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
        return dst != 5'd0 && (dst == rs || dst == rt);
    endfunction
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: pipeline-register instructions in, stall/clear controls and HI/LO status out.
interface pipe_stall_ctrl_if;
    logic [31:0] IR_D;
    logic [31:0] IR_E;
    logic [31:0] IR_M;
    logic        PC_en;
    logic        IF_ID_en;
    logic        ID_EX_clr;
    logic        md_busy;
    logic        md_done;

    modport master (output IR_D, IR_E, IR_M, input PC_en, IF_ID_en, ID_EX_clr, md_busy, md_done);
    modport slave  (input IR_D, IR_E, IR_M, output PC_en, IF_ID_en, ID_EX_clr, md_busy, md_done);
endinterface

// File: rtl/md_busy_timer.sv
// md_busy_timer: counts down the HI/LO mult/div latency after issue and flags busy/done.
module md_busy_timer
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_issue,
    input  logic i_is_div,
    output logic o_busy,
    output logic o_done
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    md_state_t     r_state, w_nxt_state;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    logic          w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // an issue seen while BUSY is ignored: the counter is never reloaded mid-operation
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_last      = 1'b0;
        if (r_state == IDLE && i_issue) begin
            w_nxt_state = BUSY;
            w_nxt_cnt   = i_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (r_state == BUSY) begin
            w_nxt_cnt   = r_cnt - CW'(1);
            w_last      = r_cnt == CW'(1);
            w_nxt_state = w_last ? IDLE : BUSY;
        end
    end

    assign o_busy = !reset && r_state == BUSY;
    assign o_done = !reset && w_last;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: load-use, branch-operand and HI/LO hazard detection driving PC/IF-ID/ID-EX stall controls.
module pipe_stall_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic              clk,
    input logic              reset,
    pipe_stall_ctrl_if.slave bus
);
    logic [4:0] w_rs, w_rt, w_dst_e, w_dst_m;
    logic       w_load_use, w_br_hazard, w_md_issue, w_md_hazard, w_stall;

    assign w_rs    = bus.IR_D[25:21];
    assign w_rt    = bus.IR_D[20:16];
    assign w_dst_e = dest_reg(bus.IR_E);
    assign w_dst_m = dest_reg(bus.IR_M);

    assign w_md_issue  = is_md(bus.IR_E);
    assign w_load_use  = is_load(bus.IR_E) && hits(w_dst_e, w_rs, w_rt);
    // branches resolve in D, so even an ALU result in E is too late to forward
    assign w_br_hazard = is_branch_d(bus.IR_D) &&
                         (hits(w_dst_e, w_rs, w_rt) || (is_load(bus.IR_M) && hits(w_dst_m, w_rs, w_rt)));
    assign w_md_hazard = (is_md(bus.IR_D) || is_hilo(bus.IR_D)) && (bus.md_busy || w_md_issue);
    assign w_stall     = !reset && (w_load_use || w_br_hazard || w_md_hazard);

    assign bus.PC_en     = !w_stall;
    assign bus.IF_ID_en  = !w_stall;
    assign bus.ID_EX_clr = w_stall;

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_issue (w_md_issue),
        .i_is_div(bus.IR_E[1]),
        .o_busy  (bus.md_busy),
        .o_done  (bus.md_done)
    );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed test-plan scenarios plus random instruction mixes checked against a cycle-count model.
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   rem = 0;

    pipe_stall_ctrl_if bus();

    pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt);
        return {op[5:0], rs[4:0], rt[4:0], 16'h0004};
    endfunction

    function automatic int f_op(input logic [31:0] ir); return int'(ir[31:26]); endfunction
    function automatic int f_fn(input logic [31:0] ir); return int'(ir[5:0]);   endfunction

    function automatic bit m_load(input logic [31:0] ir);
        int op = f_op(ir);
        return op == 32 || op == 33 || op == 35 || op == 36 || op == 37;
    endfunction

    function automatic bit m_md(input logic [31:0] ir);
        return f_op(ir) == 0 && f_fn(ir) >= 24 && f_fn(ir) <= 27;
    endfunction

    function automatic int m_dst(input logic [31:0] ir);
        int op = f_op(ir);
        int fn = f_fn(ir);
        if (op == 0) return (fn == 8 || fn == 17 || fn == 19 || m_md(ir)) ? 0 : int'(ir[15:11]);
        if (m_load(ir) || (op >= 8 && op <= 15)) return int'(ir[20:16]);
        if (op == 3) return 31;
        return 0;
    endfunction

    function automatic bit m_reads(input int dst, input logic [31:0] d);
        return dst != 0 && (dst == int'(d[25:21]) || dst == int'(d[20:16]));
    endfunction

    function automatic bit m_stall(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m, input bit r);
        bit lu  = m_load(e) && m_reads(m_dst(e), d);
        bit br  = (f_op(d) == 4 || f_op(d) == 5 || (f_op(d) == 0 && (f_fn(d) == 8 || f_fn(d) == 9))) &&
                  (m_reads(m_dst(e), d) || (m_load(m) && m_reads(m_dst(m), d)));
        bit hl  = f_op(d) == 0 && ((f_fn(d) >= 16 && f_fn(d) <= 19) || (f_fn(d) >= 24 && f_fn(d) <= 27)) &&
                  (rem > 0 || m_md(e));
        return !r && (lu || br || hl);
    endfunction

    task automatic apply(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m, input bit r);
        bit st;
        @(negedge clk);
        bus.IR_D = d;
        bus.IR_E = e;
        bus.IR_M = m;
        reset    = r;
        #1;
        st = m_stall(d, e, m, r);
        chk("ctl", {bus.PC_en, bus.IF_ID_en, bus.ID_EX_clr}, {~st, ~st, st});
        chk("md", {bus.md_busy, bus.md_done}, {!r && rem > 0, !r && rem == 1});
    endtask

    task automatic tick();
        if (reset) rem = 0;
        else if (rem > 0) rem--;
        else if (m_md(bus.IR_E)) rem = (f_fn(bus.IR_E) < 26) ? 5 : 10;
        @(posedge clk);
    endtask

    function automatic logic [31:0] rnd_ins();
        int rs = $urandom_range(0, 3);
        int rt = $urandom_range(0, 3);
        int rd = $urandom_range(0, 3);
        case ($urandom_range(0, 13))
            0: return r_ins(32, rs, rt, rd);
            1: return i_ins(35, rs, rt);
            2: return i_ins(32 + 4 * $urandom_range(0, 1), rs, rt);
            3: return i_ins(4 + $urandom_range(0, 1), rs, rt);
            4: return r_ins(8 + $urandom_range(0, 1), rs, 0, rd);
            5: return r_ins(24 + $urandom_range(0, 3), rs, rt, 0);
            6: return r_ins(16 + $urandom_range(0, 3), rs, rt, rd);
            7: return i_ins(8 + $urandom_range(0, 7), rs, rt);
            8: return {6'd3, 26'h0};
            9: return i_ins(43, rs, rt);
            10: return r_ins(17 + 2 * $urandom_range(0, 1), rs, rt, rd);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] nop, lw8, add10, div1, mult1, mflo, mfhi4, lw4;
        nop   = 32'h0;
        lw8   = i_ins(35, 9, 8);
        add10 = r_ins(32, 8, 1, 10);
        mult1 = r_ins(24, 1, 2, 0);
        div1  = r_ins(26, 1, 2, 0);
        mflo  = r_ins(18, 0, 0, 3);
        mfhi4 = r_ins(16, 0, 0, 4);
        lw4   = i_ins(35, 9, 4);
        bus.IR_D = nop; bus.IR_E = nop; bus.IR_M = nop;

        apply(add10, lw8, nop, 1'b1);
        chk("rst_pc_en", bus.PC_en, 1'b1);
        tick();
        tick();

        apply(add10, lw8, nop, 1'b0);
        chk("lu_stall", bus.ID_EX_clr, 1'b1);
        tick();
        apply(add10, nop, lw8, 1'b0);
        chk("lu_release", bus.PC_en, 1'b1);
        tick();
        apply(r_ins(32, 0, 1, 10), i_ins(35, 9, 0), nop, 1'b0);
        chk("lu_zero", bus.ID_EX_clr, 1'b0);
        tick();

        apply(i_ins(4, 5, 0), r_ins(33, 2, 3, 5), nop, 1'b0);
        chk("br_alu", bus.IF_ID_en, 1'b0);
        tick();
        apply(i_ins(4, 5, 0), i_ins(35, 9, 5), nop, 1'b0);
        chk("br_ld1", bus.ID_EX_clr, 1'b1);
        tick();
        apply(i_ins(4, 5, 0), nop, i_ins(35, 9, 5), 1'b0);
        chk("br_ld2", bus.ID_EX_clr, 1'b1);
        tick();
        apply(i_ins(4, 5, 0), nop, nop, 1'b0);
        chk("br_go", bus.PC_en, 1'b1);
        tick();

        for (int k = 0; k <= 6; k++) begin
            apply(mflo, k == 0 ? mult1 : nop, nop, 1'b0);
            chk("mult_stall", bus.ID_EX_clr, k <= 5);
            chk("mult_busy", {bus.md_busy, bus.md_done}, {k >= 1 && k <= 5, k == 5});
            tick();
        end

        for (int k = 0; k <= 11; k++) begin
            apply(r_ins(33, 1, 2, 3), k == 0 ? div1 : nop, nop, 1'b0);
            chk("div_busy", bus.md_busy, k >= 1 && k <= 10);
            chk("div_nostall", bus.PC_en, 1'b1);
            tick();
        end

        for (int k = 0; k <= 4; k++) begin
            apply(nop, k == 0 ? div1 : nop, nop, k == 3);
            if (k == 4) chk("rst_abort", {bus.md_busy, bus.md_done, bus.PC_en}, 3'b001);
            tick();
        end

        apply(mfhi4, mult1, nop, 1'b0);
        tick();
        apply(mfhi4, lw4, nop, 1'b0);
        chk("dual_stall", bus.ID_EX_clr, 1'b1);
        tick();
        apply(mfhi4, nop, lw4, 1'b0);
        chk("dual_busy", bus.ID_EX_clr, 1'b1);
        tick();

        for (int k = 0; k < 2000; k++) begin
            apply(rnd_ins(), rnd_ins(), rnd_ins(), $urandom_range(0, 63) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
